memory_top: RTL and testbench

//   Memory stage of the 5-stage RV32I pipeline. Consumes the M-stage bundle from the execute

---
 rtl/memory_top.sv | 209 ++++++++++++++++++++
 tb/tb_memory_top.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_top.sv
`default_nettype none
// ============================================================================
//  Module      : memory_top
//  Description : Memory stage of a 5-stage RV32I pipeline. Issues loads and
//                stores over a ready-handshake data-memory port, stalls the
//                front of the pipe while an access is outstanding, aborts an
//                access that waits too long, and registers the M/W outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module memory_top #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic                  MemWriteM,
    input  logic [2:0]            MemoryOpM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [ADDR_WIDTH-1:0] RdM,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    input  logic                  dmem_ready,
    output logic                  StallM,
    output logic                  RegWriteW,
    output logic [ADDR_WIDTH-1:0] RdW,
    output logic [DATA_WIDTH-1:0] ResultW,
    output logic                  MisalignW,
    output logic                  BusErrW
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // The counter holds the number of cycles already spent on the access, so
    // the cycle on which it equals TIMEOUT_CYCLES-1 is the last allowed one.
    localparam logic [4:0] c_last_wait = 5'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [4:0]              cnt_q, cnt_d;
    logic                    reg_write_w_q, reg_write_w_d;
    logic [ADDR_WIDTH-1:0]   rd_w_q, rd_w_d;
    logic [DATA_WIDTH-1:0]   result_w_q, result_w_d;
    logic                    misalign_w_q, misalign_w_d;
    logic                    bus_err_w_q, bus_err_w_d;

    logic                    w_mem_op;
    logic                    w_misaligned;
    logic                    w_issue;
    logic                    w_timeout;
    logic                    w_stall;
    logic                    w_req;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DATA_WIDTH-1:0]   w_load_data;
    logic [DATA_WIDTH-1:0]   w_result;

    // Classify the M-stage op and derive the handshake control terms.
    always_comb begin
        w_mem_op     = (ResultSrcM == 2'b01) | MemWriteM;
        w_misaligned = 1'b0;
        case (MemoryOpM[1:0])
            2'b01:   w_misaligned = ALUResultM[0];
            2'b10:   w_misaligned = |ALUResultM[1:0];
            default: w_misaligned = 1'b0;
        endcase
        w_issue   = w_mem_op & ~w_misaligned;
        w_timeout = w_issue & (state_q == S_WAIT) & (cnt_q == c_last_wait) & ~dmem_ready;
        w_stall   = w_issue & ~dmem_ready & ~w_timeout;
        // Reset gates only the externally visible request, so it drops at once.
        w_req     = w_issue & ~reset;
    end

    // Drive the memory port: lane-replicated data and byte enables, zero when idle.
    always_comb begin
        dmem_req   = w_req;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_be    = 4'b0000;
        if (w_req) begin
            dmem_we   = MemWriteM;
            dmem_addr = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
            if (MemWriteM) begin
                case (MemoryOpM[1:0])
                    2'b00: begin
                        dmem_be    = 4'b0001 << ALUResultM[1:0];
                        dmem_wdata = {4{WriteDataM[7:0]}};
                    end
                    2'b01: begin
                        dmem_be    = 4'b0011 << {ALUResultM[1], 1'b0};
                        dmem_wdata = {2{WriteDataM[15:0]}};
                    end
                    default: begin
                        dmem_be    = 4'b1111;
                        dmem_wdata = WriteDataM;
                    end
                endcase
            end else begin
                dmem_be = 4'b1111;
            end
        end
        StallM = w_stall & ~reset;
    end

    // Extract and extend the addressed load lane, then pick the writeback source.
    always_comb begin
        case (ALUResultM[1:0])
            2'b00:   w_byte = dmem_rdata[7:0];
            2'b01:   w_byte = dmem_rdata[15:8];
            2'b10:   w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = ALUResultM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (MemoryOpM)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = dmem_rdata;
        endcase
        case (ResultSrcM)
            2'b01:   w_result = w_load_data;
            2'b10:   w_result = PCPlus4M;
            default: w_result = ALUResultM;
        endcase
    end

    // Next state of the access FSM and its wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_issue & ~dmem_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = 5'd1;
                end
            end
            S_WAIT: begin
                if (~w_issue | dmem_ready | w_timeout) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // Next M/W register contents: a bubble while stalled, otherwise retire the op.
    always_comb begin
        reg_write_w_d = 1'b0;
        rd_w_d        = rd_w_q;
        result_w_d    = result_w_q;
        misalign_w_d  = 1'b0;
        bus_err_w_d   = 1'b0;
        if (!w_stall) begin
            reg_write_w_d = RegWriteM & ~w_misaligned & ~w_timeout;
            rd_w_d        = RdM;
            result_w_d    = w_result;
            misalign_w_d  = w_mem_op & w_misaligned;
            bus_err_w_d   = w_timeout;
        end
    end

    // State and M/W registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 5'd0;
            reg_write_w_q <= 1'b0;
            rd_w_q        <= '0;
            result_w_q    <= '0;
            misalign_w_q  <= 1'b0;
            bus_err_w_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            reg_write_w_q <= reg_write_w_d;
            rd_w_q        <= rd_w_d;
            result_w_q    <= result_w_d;
            misalign_w_q  <= misalign_w_d;
            bus_err_w_q   <= bus_err_w_d;
        end
    end

    assign RegWriteW = reg_write_w_q;
    assign RdW       = rd_w_q;
    assign ResultW   = result_w_q;
    assign MisalignW = misalign_w_q;
    assign BusErrW   = bus_err_w_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_top
//  Description : Self-checking bench for memory_top with a behavioural model
//                and directed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memory_top;

    localparam int TO = 4;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        RegWriteM  = 1'b0;
    logic [1:0]  ResultSrcM = 2'b00;
    logic        MemWriteM  = 1'b0;
    logic [2:0]  MemoryOpM  = 3'b000;
    logic [31:0] ALUResultM = 32'd0;
    logic [31:0] WriteDataM = 32'd0;
    logic [4:0]  RdM        = 5'd0;
    logic [31:0] PCPlus4M   = 32'd0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        dmem_ready = 1'b0;

    logic        dmem_req, dmem_we, StallM, RegWriteW, MisalignW, BusErrW;
    logic [31:0] dmem_addr, dmem_wdata, ResultW;
    logic [3:0]  dmem_be;
    logic [4:0]  RdW;

    memory_top #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .MemoryOpM(MemoryOpM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready), .StallM(StallM), .RegWriteW(RegWriteW),
        .RdW(RdW), .ResultW(ResultW), .MisalignW(MisalignW), .BusErrW(BusErrW)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          age       = 0;   // cycles the current access has already waited
    logic        m_regw    = 1'b0;
    logic        m_mis     = 1'b0;
    logic        m_bus     = 1'b0;
    logic [4:0]  m_rd      = 5'd0;
    logic [31:0] m_res     = 32'd0;
    bit          m_data_ok = 1'b1;

    function automatic bit f_mem();
        return (ResultSrcM == 2'b01) || (MemWriteM == 1'b1);
    endfunction

    function automatic bit f_mis();
        if (MemoryOpM == 3'b001 || MemoryOpM == 3'b101) return (ALUResultM % 2) != 0;
        if (MemoryOpM == 3'b010) return (ALUResultM % 4) != 0;
        return 1'b0;
    endfunction

    function automatic bit f_busy();
        return f_mem() && !f_mis();
    endfunction

    function automatic bit f_abort();
        return f_busy() && !dmem_ready && (age + 1 == TO);
    endfunction

    function automatic bit f_stall();
        return f_busy() && !dmem_ready && !f_abort();
    endfunction

    function automatic logic [31:0] f_load();
        int          sh;
        logic [31:0] v;
        if (MemoryOpM == 3'b000 || MemoryOpM == 3'b100) begin
            sh = int'(ALUResultM % 4) * 8;
            v  = (dmem_rdata >> sh) & 32'h0000_00FF;
            if (MemoryOpM == 3'b000 && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (MemoryOpM == 3'b001 || MemoryOpM == 3'b101) begin
            sh = (int'(ALUResultM % 4) / 2) * 16;
            v  = (dmem_rdata >> sh) & 32'h0000_FFFF;
            if (MemoryOpM == 3'b001 && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = dmem_rdata;
        end
        return v;
    endfunction

    function automatic logic [31:0] f_result();
        if (ResultSrcM == 2'b01) return f_load();
        if (ResultSrcM == 2'b10) return PCPlus4M;
        return ALUResultM;
    endfunction

    function automatic logic [3:0] f_be();
        int sh;
        if (!MemWriteM) return 4'hF;
        sh = int'(ALUResultM % 4);
        if (MemoryOpM[1:0] == 2'b00) return 4'(1 << sh);
        if (MemoryOpM[1:0] == 2'b01) return 4'(3 << ((sh / 2) * 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] f_wdata();
        if (MemoryOpM[1:0] == 2'b00) return {24'd0, WriteDataM[7:0]} * 32'h0101_0101;
        if (MemoryOpM[1:0] == 2'b01) return {16'd0, WriteDataM[15:0]} * 32'h0001_0001;
        return WriteDataM;
    endfunction

    // Model of the W register: advances on each clock edge, cleared by reset.
    always @(posedge clk or posedge reset) begin
        bit ab;
        if (reset) begin
            m_regw = 1'b0; m_mis = 1'b0; m_bus = 1'b0;
            m_rd = 5'd0; m_res = 32'd0; m_data_ok = 1'b1; age = 0;
        end else if (f_stall()) begin
            m_regw = 1'b0; m_mis = 1'b0; m_bus = 1'b0; m_data_ok = 1'b0;
            age = age + 1;
        end else begin
            ab        = f_abort();
            m_regw    = RegWriteM && !f_mis() && !ab;
            m_rd      = RdM;
            m_res     = f_result();
            m_mis     = f_mem() && f_mis();
            m_bus     = ab;
            m_data_ok = 1'b1;
            age       = 0;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        bit busy;
        busy = f_busy() && !reset;
        chk("dmem_req", {31'd0, dmem_req}, {31'd0, busy});
        chk("StallM", {31'd0, StallM}, {31'd0, busy && f_stall()});
        if (busy) begin
            chk("dmem_we", {31'd0, dmem_we}, {31'd0, MemWriteM});
            chk("dmem_addr", dmem_addr, ALUResultM - (ALUResultM % 4));
            chk("dmem_be", {28'd0, dmem_be}, {28'd0, f_be()});
            if (MemWriteM) chk("dmem_wdata", dmem_wdata, f_wdata());
        end else begin
            chk("idle_we", {31'd0, dmem_we}, 32'd0);
            chk("idle_addr", dmem_addr, 32'd0);
            chk("idle_be", {28'd0, dmem_be}, 32'd0);
            chk("idle_wdata", dmem_wdata, 32'd0);
        end
        chk("RegWriteW", {31'd0, RegWriteW}, {31'd0, m_regw});
        chk("MisalignW", {31'd0, MisalignW}, {31'd0, m_mis});
        chk("BusErrW", {31'd0, BusErrW}, {31'd0, m_bus});
        if (m_data_ok) begin
            chk("RdW", {27'd0, RdW}, {27'd0, m_rd});
            chk("ResultW", ResultW, m_res);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] src, input logic memw, input logic [2:0] op,
                          input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] rd, input logic regw);
        ResultSrcM = src; MemWriteM = memw; MemoryOpM = op;
        ALUResultM = alu; WriteDataM = wd; RdM = rd; RegWriteM = regw;
    endtask

    task automatic set_idle();
        set_op(2'b00, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_RegWriteW", {31'd0, RegWriteW}, 32'd0);
        chk("rst_ResultW", ResultW, 32'd0);
        reset = 1'b0;

        // LW with zero wait
        set_op(2'b01, 1'b0, 3'b010, 32'h100, 32'd0, 5'd5, 1'b1);
        dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1 chk("lw_stall", {31'd0, StallM}, 32'd0);
        tick();
        chk("lw_regw", {31'd0, RegWriteW}, 32'd1);
        chk("lw_rd", {27'd0, RdW}, 32'd5);
        chk("lw_res", ResultW, 32'hDEAD_BEEF);

        // sub-word loads
        dmem_rdata = 32'h80FF_FF7F;
        set_op(2'b01, 1'b0, 3'b000, 32'h103, 32'd0, 5'd6, 1'b1);
        tick(); chk("lb_res", ResultW, 32'hFFFF_FF80);
        set_op(2'b01, 1'b0, 3'b100, 32'h103, 32'd0, 5'd6, 1'b1);
        tick(); chk("lbu_res", ResultW, 32'h0000_0080);
        set_op(2'b01, 1'b0, 3'b001, 32'h102, 32'd0, 5'd6, 1'b1);
        tick(); chk("lh_res", ResultW, 32'hFFFF_80FF);
        set_op(2'b01, 1'b0, 3'b101, 32'h102, 32'd0, 5'd6, 1'b1);
        tick(); chk("lhu_res", ResultW, 32'h0000_80FF);

        // non-memory sources (ready is ignored with no request)
        PCPlus4M = 32'h44;
        set_op(2'b00, 1'b0, 3'b010, 32'h1234, 32'd0, 5'd7, 1'b1);
        tick(); chk("alu_res", ResultW, 32'h1234);
        set_op(2'b10, 1'b0, 3'b010, 32'h1234, 32'd0, 5'd7, 1'b1);
        tick(); chk("pc4_res", ResultW, 32'h44);

        // SB with three wait cycles
        dmem_ready = 1'b0;
        set_op(2'b00, 1'b1, 3'b000, 32'h201, 32'h0000_00AB, 5'd8, 1'b0);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (StallM === 1'b1) n++;
            chk("sb_be", {28'd0, dmem_be}, 32'h2);
            chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
            tick();
        end
        dmem_ready = 1'b1;
        #1 chk("sb_done_stall", {31'd0, StallM}, 32'd0);
        tick();
        chk("sb_stall_cycles", n, 32'd3);
        dmem_ready = 1'b0;
        set_idle();
        tick();

        // misaligned LW
        set_op(2'b01, 1'b0, 3'b010, 32'h102, 32'd0, 5'd9, 1'b1);
        #1;
        chk("mis_req", {31'd0, dmem_req}, 32'd0);
        chk("mis_stall", {31'd0, StallM}, 32'd0);
        tick();
        chk("mis_flag", {31'd0, MisalignW}, 32'd1);
        chk("mis_regw", {31'd0, RegWriteW}, 32'd0);
        set_idle();
        tick();
        chk("mis_pulse", {31'd0, MisalignW}, 32'd0);

        // LW timing out
        set_op(2'b01, 1'b0, 3'b010, 32'h100, 32'd0, 5'd10, 1'b1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (StallM !== 1'b1) break;
            n++;
            tick();
        end
        chk("to_stall_cycles", n, 32'd3);
        tick();
        chk("to_buserr", {31'd0, BusErrW}, 32'd1);
        chk("to_regw", {31'd0, RegWriteW}, 32'd0);
        set_idle();
        tick();
        chk("to_pulse", {31'd0, BusErrW}, 32'd0);

        // LW completing exactly on the timeout cycle
        dmem_rdata = 32'h1357_9BDF;
        set_op(2'b01, 1'b0, 3'b010, 32'h100, 32'd0, 5'd11, 1'b1);
        repeat (3) tick();
        dmem_ready = 1'b1;
        #1 chk("edge_stall", {31'd0, StallM}, 32'd0);
        tick();
        chk("edge_buserr", {31'd0, BusErrW}, 32'd0);
        chk("edge_regw", {31'd0, RegWriteW}, 32'd1);
        chk("edge_res", ResultW, 32'h1357_9BDF);
        dmem_ready = 1'b0;

        // reset in the middle of a wait
        set_op(2'b00, 1'b0, 3'b010, 32'h55, 32'd0, 5'd3, 1'b1);
        tick();
        set_op(2'b01, 1'b0, 3'b010, 32'h108, 32'd0, 5'd12, 1'b1);
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, StallM}, 32'd0);
        chk("rst_regw", {31'd0, RegWriteW}, 32'd0);
        chk("rst_rd", {27'd0, RdW}, 32'd0);
        chk("rst_res", ResultW, 32'd0);
        chk("rst_mis", {31'd0, MisalignW}, 32'd0);
        chk("rst_bus", {31'd0, BusErrW}, 32'd0);
        tick();
        reset = 1'b0;
        set_op(2'b01, 1'b0, 3'b010, 32'h104, 32'd0, 5'd13, 1'b1);
        dmem_ready = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        tick();
        chk("post_regw", {31'd0, RegWriteW}, 32'd1);
        chk("post_rd", {27'd0, RdW}, 32'd13);
        chk("post_res", ResultW, 32'hCAFE_F00D);
        dmem_ready = 1'b0;
        set_idle();
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
